// File: rtl/aha_platform_ctrl_pkg.sv
// Shared definitions for the platform-controller soft-reset sequencing logic:
// per-domain state encoding, domain bit positions and counter sizing.
package aha_platform_ctrl_pkg;

  localparam logic [2:0] STATE_IDLE    = 3'd0;
  localparam logic [2:0] STATE_WAKE    = 3'd1;
  localparam logic [2:0] STATE_ASSERT  = 3'd2;
  localparam logic [2:0] STATE_ACKED   = 3'd3;
  localparam logic [2:0] STATE_RELEASE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = STATE_IDLE,
    ST_WAKE    = STATE_WAKE,
    ST_ASSERT  = STATE_ASSERT,
    ST_ACKED   = STATE_ACKED,
    ST_RELEASE = STATE_RELEASE
  } dom_state_e;

  localparam int DOM_DMA0    = 0;
  localparam int DOM_DMA1    = 1;
  localparam int DOM_TLX_FWD = 2;
  localparam int DOM_TLX_REV = 3;
  localparam int DOM_CGRA    = 4;
  localparam int DOM_NIC     = 5;
  localparam int DOM_TIMER0  = 6;
  localparam int DOM_TIMER1  = 7;
  localparam int DOM_UART0   = 8;
  localparam int DOM_UART1   = 9;
  localparam int DOM_WDOG    = 10;

  // Wide enough to hold the largest phase length, so the down-counter never wraps.
  function automatic int cnt_width(input int wake, input int hold, input int rel);
    int m;
    m = wake;
    if (hold > m) m = hold;
    if (rel > m) m = rel;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/aha_reset_domain_fsm.sv
// One peripheral domain's soft-reset sequencer: wake the clock, hold reset,
// acknowledge, then keep the clock running while the domain comes out of reset.
module aha_reset_domain_fsm
  import aha_platform_ctrl_pkg::*;
#(
  parameter int WAKE_CYCLES    = 2,
  parameter int HOLD_CYCLES    = 8,
  parameter int RELEASE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic ack,
  output logic resetn,
  output logic force_on,
  output logic busy
);

  localparam int CW = cnt_width(WAKE_CYCLES, HOLD_CYCLES, RELEASE_CYCLES);
  localparam logic [CW-1:0] WAKE_LOAD = CW'(WAKE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REL_LOAD  = CW'(RELEASE_CYCLES - 1);

  dom_state_e    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          ack_reg, ack_next;
  logic          resetn_reg, resetn_next;
  logic          force_reg, force_next;
  logic          busy_reg, busy_next;

  // Domain reset is held low alongside the system reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      ack_reg    <= 1'b0;
      resetn_reg <= 1'b0;
      force_reg  <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      ack_reg    <= ack_next;
      resetn_reg <= resetn_next;
      force_reg  <= force_next;
      busy_reg   <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req) begin
          state_next = ST_WAKE;
          cnt_next   = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        if (cnt_reg == '0) begin
          state_next = ST_ASSERT;
          cnt_next   = HOLD_LOAD;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_ASSERT: begin
        if (cnt_reg == '0) begin
          state_next = ST_ACKED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      // Request is only looked at here and in IDLE; an early drop still gets a full hold.
      ST_ACKED: begin
        if (!req) begin
          state_next = ST_RELEASE;
          cnt_next   = REL_LOAD;
        end
      end
      ST_RELEASE: begin
        if (cnt_reg == '0) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase

    // Outputs are registered from the next state so they change with the state register.
    ack_next    = (state_next == ST_ACKED) || (state_next == ST_RELEASE);
    resetn_next = !((state_next == ST_ASSERT) || (state_next == ST_ACKED));
    force_next  = (state_next != ST_IDLE);
    busy_next   = (state_next != ST_IDLE);
  end

  assign ack      = ack_reg;
  assign resetn   = resetn_reg;
  assign force_on = force_reg;
  assign busy     = busy_reg;

endmodule

// File: rtl/aha_reset_handshake_ctrl.sv
// Per-peripheral soft-reset sequencer between the register space and the
// domain clock-gate / reset-synchroniser cells; one independent FSM per domain.
module aha_reset_handshake_ctrl
  import aha_platform_ctrl_pkg::*;
#(
  parameter int NUM_DOMAINS    = 11,
  parameter int WAKE_CYCLES    = 2,
  parameter int HOLD_CYCLES    = 8,
  parameter int RELEASE_CYCLES = 4
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_DOMAINS-1:0] RESET_REQ,
  input  logic [NUM_DOMAINS-1:0] CLK_GATE_EN,
  output logic [NUM_DOMAINS-1:0] RESET_ACK,
  output logic [NUM_DOMAINS-1:0] DOMAIN_RESETn,
  output logic [NUM_DOMAINS-1:0] DOMAIN_CLK_EN,
  output logic                   BUSY
);

  logic [NUM_DOMAINS-1:0] force_vec;
  logic [NUM_DOMAINS-1:0] busy_vec;

  generate
    for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_domain
      aha_reset_domain_fsm #(
        .WAKE_CYCLES   (WAKE_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES),
        .RELEASE_CYCLES(RELEASE_CYCLES)
      ) u_fsm (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .req     (RESET_REQ[gi]),
        .ack     (RESET_ACK[gi]),
        .resetn  (DOMAIN_RESETn[gi]),
        .force_on(force_vec[gi]),
        .busy    (busy_vec[gi])
      );
    end
  endgenerate

  // Software enable passes straight through so gating follows the register space with no delay.
  assign DOMAIN_CLK_EN = CLK_GATE_EN | force_vec;
  assign BUSY          = |busy_vec;

endmodule

// File: tb/tb_aha_reset_handshake_ctrl.sv
// Self-checking bench for aha_reset_handshake_ctrl: table-driven cycle vectors
// built from the documented latencies, checked through an expectation queue.
module tb_aha_reset_handshake_ctrl;

  localparam int ND = 11;
  localparam int W  = 2;
  localparam int H  = 8;
  localparam int R  = 4;
  localparam int MAXV = 64;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [ND-1:0] RESET_REQ;
  logic [ND-1:0] CLK_GATE_EN;
  logic [ND-1:0] RESET_ACK;
  logic [ND-1:0] DOMAIN_RESETn;
  logic [ND-1:0] DOMAIN_CLK_EN;
  logic          BUSY;

  aha_reset_handshake_ctrl #(
    .NUM_DOMAINS(ND), .WAKE_CYCLES(W), .HOLD_CYCLES(H), .RELEASE_CYCLES(R)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .RESET_REQ(RESET_REQ), .CLK_GATE_EN(CLK_GATE_EN),
    .RESET_ACK(RESET_ACK), .DOMAIN_RESETn(DOMAIN_RESETn), .DOMAIN_CLK_EN(DOMAIN_CLK_EN),
    .BUSY(BUSY)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [ND-1:0] ack;
    logic [ND-1:0] rstn;
    logic [ND-1:0] clken;
    logic          busy;
  } exp_t;

  typedef struct {
    logic [ND-1:0] req;
    logic [ND-1:0] gate;
    exp_t          exp;
  } vec_t;

  vec_t vecs[MAXV];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Per-domain plan: sequence 1 requested over [s1, s1+m1), an optional extra
  // request window [xa, xb), and an optional second sequence starting at s2.
  int s1[ND], m1[ND], s2[ND], m2[ND], xa[ND], xb[ND];

  // {ack, resetn, force} j cycles after the request is first driven high,
  // with the request first driven low m cycles after that.
  function automatic logic [2:0] seq_exp(input int j, input int m);
    int me;
    logic a, rn, f;
    me = (m > 1 + W + H) ? m : 1 + W + H;
    f  = (j >= 1) && (j < me + 1 + R);
    rn = !((j >= 1 + W) && (j < me + 1));
    a  = (j >= 1 + W + H) && (j < me + 1 + R);
    return {a, rn, f};
  endfunction

  task automatic clear_plan();
    for (int d = 0; d < ND; d++) begin
      s1[d] = -1; m1[d] = 0; s2[d] = -1; m2[d] = 0; xa[d] = -1; xb[d] = -1;
    end
  endtask

  task automatic build(input int n);
    logic [2:0]    e;
    logic [ND-1:0] frc;
    for (int t = 0; t < n; t++) begin
      vecs[t].req      = '0;
      vecs[t].exp.ack  = '0;
      vecs[t].exp.rstn = '1;
      frc              = '0;
      for (int d = 0; d < ND; d++) begin
        if (s1[d] >= 0) begin
          if (t >= s1[d] && t < s1[d] + m1[d]) vecs[t].req[d] = 1'b1;
          if (t >= xa[d] && t < xb[d]) vecs[t].req[d] = 1'b1;
          if (s2[d] >= 0 && t >= s2[d]) e = seq_exp(t - s2[d], m2[d]);
          else                          e = seq_exp(t - s1[d], m1[d]);
          vecs[t].exp.ack[d]  = e[2];
          vecs[t].exp.rstn[d] = e[1];
          frc[d]              = e[0];
        end
      end
      // UART0's software enable is kept off so its clock enable comes only from the sequencer.
      vecs[t].gate      = ND'($urandom) & 11'h6FF;
      vecs[t].exp.clken = vecs[t].gate | frc;
      vecs[t].exp.busy  = |frc;
    end
  endtask

  task automatic cmp(input string tag, input string fld, input int t,
                     input logic [ND-1:0] act, input logic [ND-1:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s[%0d] %s: got %03h expected %03h", tag, t, fld, act, req_v);
    end
  endtask

  task automatic check(input string tag, input int t);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s[%0d] scoreboard: no expectation queued", tag, t);
      return;
    end
    e = sb.pop_front();
    cmp(tag, "RESET_ACK",     t, RESET_ACK,     e.ack);
    cmp(tag, "DOMAIN_RESETn", t, DOMAIN_RESETn, e.rstn);
    cmp(tag, "DOMAIN_CLK_EN", t, DOMAIN_CLK_EN, e.clken);
    cmp(tag, "BUSY",          t, ND'(BUSY),     ND'(e.busy));
    $display("%s[%0d] req=%03h ack=%03h rstn=%03h clken=%03h busy=%0b",
             tag, t, RESET_REQ, RESET_ACK, DOMAIN_RESETn, DOMAIN_CLK_EN, BUSY);
  endtask

  task automatic apply(input string tag, input int n);
    for (int t = 0; t < n; t++) begin
      @(posedge HCLK); #1;
      RESET_REQ   = vecs[t].req;
      CLK_GATE_EN = vecs[t].gate;
      sb.push_back(vecs[t].exp);
      #1;
      check(tag, t);
    end
  endtask

  // Queue an expectation for a cycle with all domains idle or in system reset.
  task automatic push_quiet(input logic [ND-1:0] rstn);
    exp_t e;
    e.ack   = '0;
    e.rstn  = rstn;
    e.clken = CLK_GATE_EN;
    e.busy  = 1'b0;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn     = 1'b0;
    RESET_REQ   = '0;
    CLK_GATE_EN = '0;

    // Power-on: domains held in reset, clock enables follow software.
    for (int c = 0; c < 3; c++) begin
      @(posedge HCLK); #1;
      CLK_GATE_EN = ND'($urandom);
      push_quiet('0);
      #1;
      check("por", c);
    end
    HRESETn = 1'b1;
    #1;
    push_quiet('0);
    check("por_rel", 0);
    @(posedge HCLK); #1;
    push_quiet('1);
    #1;
    check("por_rel", 1);

    // Single domain, UART0, request held long past ack.
    clear_plan();
    s1[8] = 0; m1[8] = 14;
    build(25);
    apply("uart0", 25);

    // Short one-cycle request on DMA1: full sequence still runs.
    clear_plan();
    s1[1] = 0; m1[1] = 1;
    build(20);
    apply("short", 20);

    // DMA0 and WDOG three cycles apart.
    clear_plan();
    s1[0] = 0; m1[0] = 15;
    s1[10] = 3; m1[10] = 15;
    build(28);
    apply("concur", 28);

    // Re-request during RELEASE on TIMER0: second sequence starts from IDLE at 19.
    clear_plan();
    s1[6] = 0; m1[6] = 14;
    xa[6] = 16; xb[6] = 40;
    s2[6] = 19; m2[6] = 21;
    build(48);
    apply("rereq", 48);

    // Mid-sequence system reset on CGRA at k+6.
    clear_plan();
    s1[4] = 0; m1[4] = 14;
    build(7);
    apply("midrst", 7);
    HRESETn   = 1'b0;
    RESET_REQ = '0;
    #1;
    push_quiet('0);
    check("midrst_abort", 0);
    for (int c = 1; c < 3; c++) begin
      @(posedge HCLK); #1;
      push_quiet('0);
      #1;
      check("midrst_abort", c);
    end
    HRESETn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge HCLK); #1;
      push_quiet('1);
      #1;
      check("midrst_idle", c);
    end

    // Fresh CGRA request after the abort takes the full latency.
    clear_plan();
    s1[4] = 0; m1[4] = 12;
    build(20);
    apply("after_rst", 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
